// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN block constants, argmax FSM state encoding,
// and the class-index width used by argmax_module and argmax_cmp.
package cnn_pkg;

    localparam int NUM_CLASS_DEF = 10;
    localparam int DATA_W_DEF    = 8;
    localparam int CLS_W         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } argmax_state_e;

endpackage

// File: rtl/argmax_module_if.sv
// argmax_module_if: FC output memory port-B read bus.
// master drives omem_enb/omem_addrb and samples omem_doutb; slave is the memory.
interface argmax_module_if
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              omem_enb;
    logic [CLS_W-1:0]  omem_addrb;
    logic [DATA_W-1:0] omem_doutb;

    modport master (
        output omem_enb,
        output omem_addrb,
        input  omem_doutb
    );

    modport slave (
        input  omem_enb,
        input  omem_addrb,
        output omem_doutb
    );

endinterface

// File: rtl/argmax_cmp.sv
// argmax_cmp: running best (and, with ARGMAX_TOP2_EN, runner-up) tracker.
// Ports: clk, resetn, in_valid/in_idx/in_data sample, commit loads the
// result outputs class_id/class_score (+ second_id/margin when enabled).
module argmax_cmp
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [CLS_W-1:0]         in_idx,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     commit,
    output logic [CLS_W-1:0]         class_id,
    output logic signed [DATA_W-1:0] class_score
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [CLS_W-1:0]         second_id,
    output logic [DATA_W:0]          margin
`endif
);

    localparam logic signed [DATA_W-1:0] SMIN =
        {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] best_q, best_d;
    logic [CLS_W-1:0]         bid_q, bid_d;

`ifdef ARGMAX_TOP2_EN
    logic signed [DATA_W-1:0] sec_q, sec_d;
    logic [CLS_W-1:0]         sid_q, sid_d;
    logic                     sec_v_q, sec_v_d;
    logic [DATA_W:0]          diff;
`endif

    // Index 0 always seeds the run; later samples win only when strictly
    // greater, so the lowest index keeps a tie.
    always_comb begin
        best_d = best_q;
        bid_d  = bid_q;
`ifdef ARGMAX_TOP2_EN
        sec_d   = sec_q;
        sid_d   = sid_q;
        sec_v_d = sec_v_q;
`endif
        if (in_valid) begin
            if (in_idx == '0) begin
                best_d = in_data;
                bid_d  = '0;
`ifdef ARGMAX_TOP2_EN
                sec_d   = SMIN;
                sid_d   = '0;
                sec_v_d = 1'b0;
`endif
            end else if (in_data > best_q) begin
                best_d = in_data;
                bid_d  = in_idx;
`ifdef ARGMAX_TOP2_EN
                sec_d   = best_q;
                sid_d   = bid_q;
                sec_v_d = 1'b1;
`endif
            end
`ifdef ARGMAX_TOP2_EN
            else if (!sec_v_q || (in_data > sec_q)) begin
                // A tie with best lands here, making the later index
                // runner-up with a zero margin.
                sec_d   = in_data;
                sid_d   = in_idx;
                sec_v_d = 1'b1;
            end
`endif
        end
    end

`ifdef ARGMAX_TOP2_EN
    assign diff = {best_d[DATA_W-1], best_d} - {sec_d[DATA_W-1], sec_d};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            best_q <= '0;
            bid_q  <= '0;
`ifdef ARGMAX_TOP2_EN
            sec_q   <= SMIN;
            sid_q   <= '0;
            sec_v_q <= 1'b0;
`endif
        end else begin
            best_q <= best_d;
            bid_q  <= bid_d;
`ifdef ARGMAX_TOP2_EN
            sec_q   <= sec_d;
            sid_q   <= sid_d;
            sec_v_q <= sec_v_d;
`endif
        end
    end

    // Results load from the next-state values so the final compare and
    // the commit happen on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            class_id    <= '0;
            class_score <= '0;
`ifdef ARGMAX_TOP2_EN
            second_id <= '0;
            margin    <= '0;
`endif
        end else if (commit) begin
            class_id    <= bid_d;
            class_score <= best_d;
`ifdef ARGMAX_TOP2_EN
            second_id <= sid_d;
            margin    <= diff;
`endif
        end
    end

endmodule

// File: rtl/argmax_module.sv
// argmax_module: reads NUM_CLASS logits from omem port B and reports the
// index/value of the maximum. Ports: clk, resetn, start, done, busy,
// omem (argmax_module_if.master), class_id, class_score, class_valid;
// second_id/margin added when ARGMAX_TOP2_EN is defined. RD_LAT >= 1.
module argmax_module
    import cnn_pkg::*;
#(
    parameter int NUM_CLASS = NUM_CLASS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    output logic                     done,
    output logic                     busy,
    argmax_module_if.master          omem,
    output logic [CLS_W-1:0]         class_id,
    output logic signed [DATA_W-1:0] class_score,
    output logic                     class_valid
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [CLS_W-1:0]         second_id,
    output logic [DATA_W:0]          margin
`endif
);

    localparam logic [CLS_W-1:0] LAST = CLS_W'(NUM_CLASS - 1);

    argmax_state_e state, state_n;

    logic             enb_q;
    logic [CLS_W-1:0] addr_q;
    logic             accept;
    logic             fin;
    logic             cls_v_q;

    // Tracks each issued read until its data appears on omem_doutb.
    logic [RD_LAT-1:0] pipe_v;
    logic [CLS_W-1:0]  pipe_idx [RD_LAT];

    logic signed [DATA_W-1:0] rd_data;

    assign rd_data         = omem.omem_doutb;
    assign omem.omem_enb   = enb_q;
    assign omem.omem_addrb = addr_q;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign fin    = (state == DRAIN) && pipe_v[RD_LAT-1]
                    && (pipe_idx[RD_LAT-1] == LAST);

    assign done        = (state == DONE);
    assign busy        = (state == READ) || (state == DRAIN);
    assign class_valid = cls_v_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = READ;
            READ:    if (addr_q == LAST) state_n = DRAIN;
            DRAIN:   if (fin) state_n = DONE;
            DONE:    state_n = start ? READ : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enb_q  <= 1'b0;
            addr_q <= '0;
        end else if (accept) begin
            enb_q  <= 1'b1;
            addr_q <= '0;
        end else if (state == READ) begin
            if (addr_q == LAST) begin
                enb_q  <= 1'b0;
                addr_q <= '0;
            end else begin
                addr_q <= addr_q + CLS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_v[k]   <= 1'b0;
                pipe_idx[k] <= '0;
            end
        end else begin
            pipe_v[0]   <= enb_q;
            pipe_idx[0] <= addr_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v[k]   <= pipe_v[k-1];
                pipe_idx[k] <= pipe_idx[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     cls_v_q <= 1'b0;
        else if (fin)    cls_v_q <= 1'b1;
        else if (accept) cls_v_q <= 1'b0;
    end

    argmax_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (pipe_v[RD_LAT-1]),
        .in_idx      (pipe_idx[RD_LAT-1]),
        .in_data     (rd_data),
        .commit      (fin),
        .class_id    (class_id),
        .class_score (class_score)
`ifdef ARGMAX_TOP2_EN
        ,
        .second_id   (second_id),
        .margin      (margin)
`endif
    );

endmodule

// File: tb/tb_argmax_module.sv
// tb_argmax_module: directed and randomized checks of argmax_module
// against an array-based argmax reference model.
module tb_argmax_module;

    localparam int NC = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic resetn;
    logic start;
    logic done;
    logic busy;
    logic [3:0] class_id;
    logic signed [DW-1:0] class_score;
    logic class_valid;
`ifdef ARGMAX_TOP2_EN
    logic [3:0] second_id;
    logic [DW:0] margin;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic signed [DW-1:0] mem [NC];

    int exp_id, exp_sc, exp_sid, exp_mg;

    always #5 clk = ~clk;

    argmax_module_if #(.DATA_W(DW)) omem_bus ();

    argmax_module #(
        .NUM_CLASS (NC),
        .DATA_W    (DW),
        .RD_LAT    (1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .done        (done),
        .busy        (busy),
        .omem        (omem_bus.master),
        .class_id    (class_id),
        .class_score (class_score),
        .class_valid (class_valid)
`ifdef ARGMAX_TOP2_EN
        ,
        .second_id   (second_id),
        .margin      (margin)
`endif
    );

    // Synchronous-read memory, one cycle latency.
    always @(posedge clk) begin
        if (omem_bus.omem_enb) begin
            if (int'(omem_bus.omem_addrb) < NC)
                omem_bus.omem_doutb <= mem[int'(omem_bus.omem_addrb)];
            else
                omem_bus.omem_doutb <= '0;
        end
    end

    // Max with first-occurrence tie break; runner-up is the best of the
    // remaining entries, again first occurrence.
    function automatic void ref_model();
        int bi, si;
        bi = 0;
        for (int i = 1; i < NC; i++)
            if (int'(mem[i]) > int'(mem[bi])) bi = i;
        si = -1;
        for (int i = 0; i < NC; i++)
            if (i != bi && (si < 0 || int'(mem[i]) > int'(mem[si]))) si = i;
        exp_id  = bi;
        exp_sc  = int'(mem[bi]);
        exp_sid = si;
        exp_mg  = int'(mem[bi]) - int'(mem[si]);
    endfunction

    task automatic fill_random(input bit narrow);
        for (int i = 0; i < NC; i++) begin
            if (narrow) mem[i] = 8'(int'($urandom_range(0, 3)) * 40 - 60);
            else        mem[i] = 8'($urandom);
        end
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered mid-cycle 1 of a run; checks every cycle through cycle 13.
    // poke_at raises start during that cycle; 12 chains a new run.
    task automatic check_run(input string tag, input int poke_at);
        ref_model();
        for (int cyc = 1; cyc <= 13; cyc++) begin
            start = (cyc == poke_at);
            vectors++;
            if (omem_bus.omem_enb !== (cyc <= NC)) begin
                miscompares++;
                $display("FAIL %s enb c%0d got=%b exp=%b", tag, cyc,
                         omem_bus.omem_enb, (cyc <= NC));
            end
            if (cyc <= NC) begin
                vectors++;
                if (omem_bus.omem_addrb !== 4'(cyc - 1)) begin
                    miscompares++;
                    $display("FAIL %s addr c%0d got=%0d exp=%0d", tag, cyc,
                             omem_bus.omem_addrb, cyc - 1);
                end
            end
            vectors++;
            if (done !== (cyc == 12)) begin
                miscompares++;
                $display("FAIL %s done c%0d got=%b", tag, cyc, done);
            end
            if (cyc <= 11) begin
                vectors++;
                if (busy !== 1'b1 || class_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s busy/valid c%0d got=%b/%b exp=1/0",
                             tag, cyc, busy, class_valid);
                end
            end else begin
                vectors++;
                if (class_valid !== 1'b1 || class_id !== 4'(exp_id)
                    || class_score !== 8'(exp_sc)) begin
                    miscompares++;
                    $display("FAIL %s result c%0d got=%b/%0d/%0d exp=1/%0d/%0d",
                             tag, cyc, class_valid, class_id, class_score,
                             exp_id, exp_sc);
                end
`ifdef ARGMAX_TOP2_EN
                vectors++;
                if (second_id !== 4'(exp_sid) || margin !== 9'(exp_mg)) begin
                    miscompares++;
                    $display("FAIL %s top2 c%0d got=%0d/%0d exp=%0d/%0d",
                             tag, cyc, second_id, margin, exp_sid, exp_mg);
                end
`endif
            end
            if (cyc == 13) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s idle_busy got=%b exp=0", tag, busy);
                end
            end
            if (cyc == 12 && poke_at == 12) begin
                fill_random(1'b0);
                @(negedge clk);
                start = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({done, busy, omem_bus.omem_enb, omem_bus.omem_addrb, class_id,
             class_score, class_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs not zero d=%b b=%b e=%b a=%0d id=%0d s=%0d v=%b",
                     done, busy, omem_bus.omem_enb, omem_bus.omem_addrb,
                     class_id, class_score, class_valid);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_equal();
        for (int i = 0; i < NC; i++) mem[i] = 8'h10;
        launch();
        check_run("all_equal", 0);
    endtask

    task automatic test_last_max();
        for (int i = 0; i < NC; i++) mem[i] = -8'sd1;
        mem[9] = 8'sd127;
        launch();
        check_run("last_max", 0);
    endtask

    task automatic test_min_values();
        for (int i = 0; i < NC; i++) mem[i] = 8'h80;
        mem[4] = -8'sd5;
        launch();
        check_run("min_values", 0);
    endtask

    task automatic test_tie();
        for (int i = 0; i < NC; i++) mem[i] = 8'sd20;
        mem[3] = 8'sd50;
        mem[7] = 8'sd50;
        launch();
        check_run("tie", 0);
    endtask

    task automatic test_ignored_start();
        fill_random(1'b0);
        launch();
        check_run("ignored_start", 5);
    endtask

    task automatic test_random();
        for (int r = 0; r < 16; r++) begin
            fill_random(r[0]);
            launch();
            check_run("random", 0);
        end
    endtask

    task automatic test_back_to_back();
        fill_random(1'b1);
        launch();
        check_run("b2b_first", 12);
        check_run("b2b_second", 0);
    endtask

    task automatic test_reset_mid_run();
        fill_random(1'b0);
        launch();
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if ({done, busy, omem_bus.omem_enb, omem_bus.omem_addrb, class_id,
             class_score, class_valid} !== '0) begin
            miscompares++;
            $display("FAIL midreset outputs not zero d=%b b=%b e=%b a=%0d id=%0d s=%0d v=%b",
                     done, busy, omem_bus.omem_enb, omem_bus.omem_addrb,
                     class_id, class_score, class_valid);
        end
`ifdef ARGMAX_TOP2_EN
        vectors++;
        if (second_id !== '0 || margin !== '0) begin
            miscompares++;
            $display("FAIL midreset top2 got=%0d/%0d exp=0/0",
                     second_id, margin);
        end
`endif
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0
                || omem_bus.omem_enb !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset idle i%0d got d/b/e=%b/%b/%b exp=0/0/0",
                         i, done, busy, omem_bus.omem_enb);
            end
        end
        fill_random(1'b1);
        launch();
        check_run("post_reset", 0);
    endtask

    initial begin
        start = 1'b0;
        for (int i = 0; i < NC; i++) mem[i] = '0;
        test_reset();
        test_all_equal();
        test_last_max();
        test_min_values();
        test_tie();
        test_ignored_start();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/argmax_module.md
ARGMAX_MODULE -- requirements
Module: argmax_module

Interface
REQ-001 SHALL have parameter NUM_CLASS, default 10: number of logits read from the FC output memory.
REQ-002 SHALL have parameter DATA_W, default 8: logit width, signed two's complement.
REQ-003 SHALL have parameter RD_LAT, default 1: omem port-B read latency in cycles.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle request to classify the current omem contents.
REQ-007 SHALL have port done, output, 1: one-cycle pulse when the result is final.
REQ-008 SHALL have port busy, output, 1: high from the cycle after an accepted start until the cycle done is high.
REQ-009 SHALL have port omem_enb, output, 1: omem port-B read enable.
REQ-010 SHALL have port omem_addrb, output, 4: omem port-B read address.
REQ-011 SHALL have port omem_doutb, input, DATA_W: omem port-B read data.
REQ-012 SHALL have port class_id, output, 4: index of the maximum logit.
REQ-013 SHALL have port class_score, output, DATA_W: value of the maximum logit, signed.
REQ-014 SHALL have port class_valid, output, 1: class_id and class_score hold a completed result.

Function
REQ-015 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
- IDLE/DONE --start--> READ.
- READ --last address issued--> DRAIN.
- DRAIN --last compare done--> DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start in READ or DRAIN is ignored, with no restart and no output change.
REQ-017 Address issue SHALL follow this timing:
- edge E0 samples start;
- cycles 1..NUM_CLASS drive omem_enb=1 with omem_addrb = 0..NUM_CLASS-1, one per cycle, ascending;
- omem_enb=0 otherwise.
REQ-018 SHALL sample omem_doutb for address i in cycle i+1+RD_LAT, using a valid/index shift register of depth RD_LAT that tracks the issued reads.
REQ-019 SHALL load the first sample (index 0) unconditionally into the best register; each later sample replaces best only if strictly greater (signed compare), so ties go to the lowest index.
REQ-020 SHALL make the last compare at the end of cycle NUM_CLASS+RD_LAT; done=1 in cycle NUM_CLASS+RD_LAT+1 (cycle 12 for the defaults).
REQ-021 SHALL set class_valid=0 on an accepted start and set it to 1 together with done; it then holds until the next accepted start or reset.
REQ-022 SHALL update class_id and class_score only in the cycle done asserts; they are stable while class_valid=1.
REQ-023 SHALL treat -128 as the minimum value; all-negative inputs are valid and yield the least-negative logit.
REQ-024 SHALL accept start in the same cycle done is high (DONE state) and begin a new run; done is still emitted exactly once for the previous run.

Reset
REQ-025 On resetn=0 SHALL asynchronously force: state=IDLE, done=0, busy=0, omem_enb=0, omem_addrb=0, class_id=0, class_score=0, class_valid=0, and clear all pipeline valids.
REQ-026 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-027 When macro ARGMAX_TOP2_EN is defined, SHALL add:
- outputs second_id (4) and margin (DATA_W+1, unsigned) = class_score - second-highest score;
- second_id is the runner-up index, with the lowest-index tie rule;
- equal top scores give margin=0 and second_id = the higher tied index;
- these outputs follow the class_id timing and reset rules.
REQ-028 When ARGMAX_TOP2_EN is undefined, SHALL have no such ports or logic.

Structure
REQ-029 SHALL place NUM_CLASS default, DATA_W default, the FSM state encoding, and the class-index width in shared package cnn_pkg.
REQ-030 SHALL implement the compare/replace datapath (best and optional second) as sub-module argmax_cmp; the FSM and address generation stay in argmax_module.

Verification
REQ-031 All logits = 0x10 -> class_id=0, class_score=0x10, done in cycle 12 after start.
REQ-032 Logits 0..8 = -1, logit 9 = 127 -> class_id=9, class_score=127.
REQ-033 All logits -128 except index 4 = -5 -> class_id=4, class_score=-5.
REQ-034 Indices 3 and 7 = 50, others 20 -> class_id=3. With ARGMAX_TOP2_EN: second_id=7, margin=0.
REQ-035 Second start pulsed at cycle 5 -> ignored, single done at cycle 12, result unchanged.
REQ-036 resetn low at cycle 6 -> all outputs 0, no done pulse; a new start then completes normally with the correct result.
